// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared sizes and FSM state encoding for the BCD-to-binary converter
package bcd_pkg;

  localparam int NDIG  = 6;
  localparam int LANE  = 16;
  localparam int BIN_W = 20;
  // One spare lane on the bus; its bits are never read.
  localparam int BCD_W = (NDIG + 1) * LANE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - request/result handshake bundle for bcd_to_bin_seq
interface bcd_to_bin_seq_if #(
  parameter int BCD_W = bcd_pkg::BCD_W,
  parameter int BIN_W = bcd_pkg::BIN_W
);

  logic             start_valid;
  logic             start_ready;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] bin;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  modport master (
    output start_valid, bcd, out_ready,
    input  start_ready, bin, out_valid, err
  );

  modport slave (
    input  start_valid, bcd, out_ready,
    output start_ready, bin, out_valid, err
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - combinational acc*10 + digit, truncated to BIN_W bits
module bcd_digit_mac #(
  parameter int BIN_W = bcd_pkg::BIN_W
) (
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [BIN_W-1:0] o_sum
);

  logic [BIN_W-1:0] w_digit;

  assign w_digit = {{(BIN_W-4){1'b0}}, i_digit};
  assign o_sum   = (i_acc << 3) + (i_acc << 1) + w_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter, one digit per cycle, MSD first
module bcd_to_bin_seq #(
  parameter int NDIG  = bcd_pkg::NDIG,
  parameter int LANE  = bcd_pkg::LANE,
  parameter int BIN_W = bcd_pkg::BIN_W
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_bin_seq_if.slave  bus
);

  import bcd_pkg::*;

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CONV = CONV;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]          r_state;
  logic [NDIG*LANE-1:0] r_bcd;
  logic [BIN_W-1:0]    r_acc;
  logic [BIN_W-1:0]    r_bin;
  logic [IDX_W-1:0]    r_idx;
  logic                r_err;

  logic [LANE-1:0]     w_lane;
  logic                w_lane_bad;
  logic [BIN_W-1:0]    w_mac;

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IDX_W'(i)) w_lane = r_bcd[i*LANE +: LANE];
    end
  end

  // The whole lane is range-checked, but only its low nibble feeds the sum.
  assign w_lane_bad = (w_lane > LANE'(9));

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .i_acc   (r_acc),
    .i_digit (w_lane[3:0]),
    .o_sum   (w_mac)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bcd   <= '0;
      r_acc   <= '0;
      r_bin   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_bcd   <= bus.bcd[NDIG*LANE-1:0];
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_idx   <= IDX_W'(NDIG-1);
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_acc <= w_mac;
          if (w_lane_bad) r_err <= 1'b1;
          if (r_idx == '0) begin
            r_bin   <= w_mac;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.out_valid   = (r_state == ST_DONE);
  assign bus.bin         = r_bin;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq_if bus ();

  bcd_to_bin_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [BCD_W-1:0] pack(input logic [15:0] top,
                                            input logic [15:0] d5, d4, d3, d2, d1, d0);
    return {top, d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [BCD_W-1:0] v);
    chk({tag, "_start_ready"}, {31'd0, bus.start_ready}, 32'd1);
    bus.bcd         = v;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
  endtask

  // Result must appear exactly NDIG edges after the accepting edge.
  task automatic expect_result(input string tag, input logic [31:0] exp_bin, input logic exp_err);
    logic early;
    early = 1'b0;
    for (int i = 1; i < NDIG; i++) begin
      step();
      early = early | bus.out_valid;
    end
    chk({tag, "_early_valid"}, {31'd0, early}, 32'd0);
    step();
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_bin"}, {12'd0, bus.bin}, exp_bin);
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_back_idle"}, {31'd0, bus.start_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b1;
    bus.bcd         = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_bin", {12'd0, bus.bin}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);

    // Upper spare lane carries garbage that must be ignored.
    accept("v123456", pack(16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6));
    expect_result("v123456", 32'h1E240, 1'b0);
    consume("v123456");

    accept("v999999", pack(16'h0, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9));
    expect_result("v999999", 32'hF423F, 1'b0);
    consume("v999999");

    accept("v000000", pack(16'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0));
    expect_result("v000000", 32'd0, 1'b0);
    consume("v000000");

    // Bad lanes: bin is still the low-nibble accumulation (C*100, 5*100).
    accept("d2_0C", pack(16'h0, 16'd0, 16'd0, 16'd0, 16'h000C, 16'd0, 16'd0));
    expect_result("d2_0C", 32'd1200, 1'b1);
    consume("d2_0C");

    accept("d2_105", pack(16'h0, 16'd0, 16'd0, 16'd0, 16'h0105, 16'd0, 16'd0));
    expect_result("d2_105", 32'd500, 1'b1);
    consume("d2_105");

    // Stall in DONE with start_valid pulses that must be ignored.
    bus.out_ready = 1'b0;
    accept("stall", pack(16'h0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6));
    expect_result("stall", 32'h1E240, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.bcd         = pack(16'h0, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
      bus.start_valid = (i % 2 == 0);
      step();
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_bin", {12'd0, bus.bin}, 32'h1E240);
      chk("stall_err", {31'd0, bus.err}, 32'd0);
      chk("stall_start_ready", {31'd0, bus.start_ready}, 32'd0);
    end
    // start_valid held through the consuming edge must not be taken that cycle.
    bus.start_valid = 1'b1;
    consume("stall");
    bus.start_valid = 1'b0;
    chk("idle_bin_hold", {12'd0, bus.bin}, 32'h1E240);
    step();
    chk("idle_stays_idle", {31'd0, bus.start_ready}, 32'd1);

    // Reset in the third CONV cycle aborts the conversion.
    accept("abort", pack(16'h0, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_bin", {12'd0, bus.bin}, 32'd0);
    chk("abort_err", {31'd0, bus.err}, 32'd0);
    chk("abort_start_ready", {31'd0, bus.start_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | bus.out_valid;
    end
    chk("abort_no_result", {31'd0, seen}, 32'd0);

    // Input changes after the accepting edge are not seen.
    accept("v000042", pack(16'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd2));
    bus.bcd = pack(16'h0, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
    expect_result("v000042", 32'd42, 1'b0);
    consume("v000042");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 Parameter NDIG, default 6: number of BCD digits converted.
REQ-002 Parameter LANE, default 16: bit width of each packed digit lane.
REQ-003 Parameter BIN_W, default 20: output binary width, enough for 999999.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_valid  input  1  request to convert the value on bcd.
REQ-007 start_ready  output  1  block can accept a request.
REQ-008 bcd  input  112  packed digits; digit i occupies bits [16i+15:16i], i=0 is the ones place, i=0..5; bits 111:96 are ignored.
REQ-009 bin  output  BIN_W  converted binary result.
REQ-010 out_valid  output  1  bin and err are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 err  output  1  at least one lane held a value greater than 9.

Function
REQ-013 The block SHALL be an FSM with states IDLE, CONV and DONE.
REQ-014 IDLE: start_ready=1 and out_valid=0.
- On start_valid&start_ready, capture bcd, clear acc and err, set idx=NDIG-1, and go to CONV.
REQ-015 CONV: start_ready=0; each cycle acc <= (acc*10 + lane[idx][3:0]) mod 2^BIN_W.
- If lane[idx] (full 16 bits) > 9, set err sticky.
- Decrement idx; after idx==0 is processed, go to DONE.
REQ-016 Processing SHALL be MSD first, one digit per cycle.
- out_valid SHALL rise exactly NDIG cycles after the accepting edge (6 with defaults).
REQ-017 DONE: out_valid=1; bin=acc and err stay stable until out_valid&out_ready.
- On that handshake, go to IDLE with out_valid=0 on the next cycle.
REQ-018 start_valid SHALL be ignored in CONV and DONE.
- No new request is accepted in the same cycle a result is consumed.
REQ-019 Changes on bcd after the accepting edge SHALL NOT affect the result.
REQ-020 With err=1, bin SHALL still be the truncated mod-2^BIN_W accumulation of the low nibbles.
- Consumers treat bin as undefined in that case.
REQ-021 bin SHALL hold its last value in IDLE until the next conversion overwrites it.

Reset
REQ-022 While rst=1 on a rising edge, the block SHALL set state=IDLE, acc=0, idx=0, err=0, bin=0 and out_valid=0.
- start_ready SHALL be 1 in the cycle after reset.
REQ-023 rst asserted during CONV or DONE SHALL abort the conversion with no result emitted.

Structure
REQ-024 Package bcd_pkg SHALL hold NDIG, LANE, BIN_W and the state enum (IDLE, CONV, DONE).
REQ-025 One combinational sub-module, bcd_digit_mac, SHALL compute acc*10+digit.
- It is built as (acc<<3)+(acc<<1)+digit; the FSM and registers stay in bcd_to_bin_seq.

Verification
REQ-026 Digits (d5..d0)=1,2,3,4,5,6, out_ready=1 -> bin=123456 (0x1E240), err=0, out_valid exactly 6 cycles after accept and for 1 cycle.
REQ-027 All digits 9 -> bin=999999 (0xF423F), err=0; all digits 0 -> bin=0, err=0.
REQ-028 d2=0x000C, others 0 -> err=1 with out_valid; lane d2=0x0105 -> err=1.
REQ-029 out_ready held 0 for 5 cycles after out_valid -> bin/err/out_valid stable, start_ready=0, start_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-030 rst=1 for 1 cycle at the 3rd CONV cycle -> next cycle out_valid=0, bin=0, err=0, start_ready=1; no result appears.
REQ-031 bcd changed to all 9s one cycle after accepting 000042 -> bin=42.
